// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the compare scheduler.
//   CMP_* op codes   funct3-style compare selectors (010/011 are illegal)
//   NPORT            number of requesting ports
//   s1_entry_t       contents of the compare stage {a, b, op, port, tag}
package cmp_pkg;

   localparam int CMP_XLEN = 64;
   localparam int CMP_TAGW = 4;
   localparam int NPORT    = 2;

   localparam logic [2:0] CMP_EQ    = 3'b000;
   localparam logic [2:0] CMP_NEQ   = 3'b001;
   localparam logic [2:0] CMP_SLT   = 3'b100;
   localparam logic [2:0] CMP_SNLT  = 3'b101;
   localparam logic [2:0] CMP_USLT  = 3'b110;
   localparam logic [2:0] CMP_USNLT = 3'b111;

   typedef struct packed {
      logic [CMP_XLEN-1:0] a;
      logic [CMP_XLEN-1:0] b;
      logic [2:0]          op;
      logic                port;
      logic [CMP_TAGW-1:0] tag;
   } s1_entry_t;

endpackage

// File: rtl/comparator.sv
// comparator: purely combinational 64-bit compare unit.
//   a, b    operands
//   eq/neq  equality and its complement
//   slt     signed a < b,   snlt  its complement
//   uslt    unsigned a < b, usnlt its complement
module comparator #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            eq,
   output logic            neq,
   output logic            slt,
   output logic            snlt,
   output logic            uslt,
   output logic            usnlt
);

   always_comb begin
      eq    = (a == b);
      neq   = ~eq;
      slt   = ($signed(a) < $signed(b));
      snlt  = ~slt;
      uslt  = (a < b);
      usnlt = ~uslt;
   end

endmodule

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin scheduler sharing one comparator between two ports.
//   clk, rst_n     clock (rising edge), async active-low reset
//   req_valid/ready  per-port request handshake; req_op/req_a/req_b/req_tag payload
//   rsp_valid/ready  per-port response handshake
//   rsp_result     0 or 1, shared by both ports; rsp_tag echoes the request tag
// Pipeline: S1 registers the granted request and feeds the comparator,
// S2 registers the selected compare bit and drives the response outputs.
//
// Handshake rule (both directions): a transfer happens on a rising edge where
// valid and ready are both high. A producer holds valid and payload until the
// transfer; ready may depend combinationally on valid, valid never on ready.
module cmp_sched
   import cmp_pkg::*;
#(
   parameter int XLEN = CMP_XLEN,
   parameter int TAGW = CMP_TAGW
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NPORT-1:0]           req_valid,
   output logic [NPORT-1:0]           req_ready,
   input  logic [NPORT-1:0][2:0]      req_op,
   input  logic [NPORT-1:0][XLEN-1:0] req_a,
   input  logic [NPORT-1:0][XLEN-1:0] req_b,
   input  logic [NPORT-1:0][TAGW-1:0] req_tag,
   output logic [NPORT-1:0]           rsp_valid,
   input  logic [NPORT-1:0]           rsp_ready,
   output logic [XLEN-1:0]            rsp_result,
   output logic [TAGW-1:0]            rsp_tag
);

   s1_entry_t        s1_q;
   logic             s1_valid;
   logic             s2_valid;
   logic             s2_port;
   logic             s2_bit;
   logic [TAGW-1:0]  s2_tag;
   logic             rr_ptr;

   logic             s2_drain;
   logic             s1_adv;
   logic             s1_open;
   logic [NPORT-1:0] win;
   logic [NPORT-1:0] gnt;
   logic             gnt_port;
   logic             cmp_bit;

   logic c_eq, c_neq, c_slt, c_snlt, c_uslt, c_usnlt;

   comparator #(.XLEN(XLEN)) u_comparator (
      .a     (s1_q.a),
      .b     (s1_q.b),
      .eq    (c_eq),
      .neq   (c_neq),
      .slt   (c_slt),
      .snlt  (c_snlt),
      .uslt  (c_uslt),
      .usnlt (c_usnlt)
   );

   always_comb begin
      s2_drain = s2_valid & rsp_ready[s2_port];
      s1_adv   = s1_valid & (~s2_valid | s2_drain);
      // S1 can take a new request when empty or when its content moves on
      // this same edge, so streaming needs no bubble.
      s1_open  = ~s1_valid | s1_adv;
      // A lone requester wins outright; rr_ptr only breaks ties.
      win[0]   = req_valid[0] & (~req_valid[1] | ~rr_ptr);
      win[1]   = req_valid[1] & (~req_valid[0] |  rr_ptr);
      req_ready = win & {NPORT{s1_open}};
      gnt      = req_valid & req_ready;
      gnt_port = gnt[1];
   end

   always_comb begin
      cmp_bit = 1'b0;
      case (s1_q.op)
         CMP_EQ:    cmp_bit = c_eq;
         CMP_NEQ:   cmp_bit = c_neq;
         CMP_SLT:   cmp_bit = c_slt;
         CMP_SNLT:  cmp_bit = c_snlt;
         CMP_USLT:  cmp_bit = c_uslt;
         CMP_USNLT: cmp_bit = c_usnlt;
         default:   cmp_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         rr_ptr   <= 1'b0;
      end else begin
         if (|gnt) begin
            s1_valid <= 1'b1;
            s1_q.a   <= req_a[gnt_port];
            s1_q.b   <= req_b[gnt_port];
            s1_q.op  <= req_op[gnt_port];
            s1_q.port <= gnt_port;
            s1_q.tag <= req_tag[gnt_port];
            // Point at the port that did not just win.
            rr_ptr   <= ~gnt_port;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_port  <= 1'b0;
         s2_bit   <= 1'b0;
         s2_tag   <= '0;
      end else begin
         if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_port  <= s1_q.port;
            s2_bit   <= cmp_bit;
            s2_tag   <= s1_q.tag;
         end else if (s2_drain) begin
            s2_valid <= 1'b0;
         end
      end
   end

   // Response outputs are decoded from S2 registers only.
   assign rsp_valid  = {s2_valid & s2_port, s2_valid & ~s2_port};
   assign rsp_result = {{(XLEN-1){1'b0}}, s2_bit};
   assign rsp_tag    = s2_tag;

endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: directed bench for cmp_sched.
module tb_cmp_sched;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][2:0]  req_op;
   logic [1:0][63:0] req_a;
   logic [1:0][63:0] req_b;
   logic [1:0][3:0]  req_tag;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [63:0]      rsp_result;
   logic [3:0]       rsp_tag;

   int checks = 0;
   int errors = 0;

   // {port, tag, result}
   logic [68:0] exp_q[$];

   typedef struct {
      logic        port;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  tag;
      logic        exp;
   } vec_t;

   vec_t vecs[14];

   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINS = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MAXS = 64'h7FFF_FFFF_FFFF_FFFF;

   cmp_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_tag    (rsp_tag)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic ref_cmp(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return !($signed(a) < $signed(b));
         3'b110:  return a < b;
         3'b111:  return !(a < b);
         default: return 1'b0;
      endcase
   endfunction

   // scoreboard: compare the visible response against the queue head and
   // retire it when the handshake will complete on the coming edge
   task automatic monitor();
      logic [68:0] e;
      if (rsp_valid != 2'b00) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=%b required=00", rsp_valid);
         end else begin
            e = exp_q[0];
            chk("rsp_valid", 64'(rsp_valid), e[68] ? 64'd2 : 64'd1);
            chk("rsp_tag", 64'(rsp_tag), 64'(e[67:64]));
            chk("rsp_result", rsp_result, e[63:0]);
            if ((rsp_valid & rsp_ready) != 2'b00) void'(exp_q.pop_front());
         end
      end
   endtask

   // driver tasks
   task automatic cycle_begin();
      @(negedge clk);
   endtask

   task automatic cycle_end(output logic [1:0] g);
      #1;
      monitor();
      g = req_valid & req_ready;
   endtask

   task automatic set_req(input int p, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tag);
      req_op[p]  = op;
      req_a[p]   = a;
      req_b[p]   = b;
      req_tag[p] = tag;
   endtask

   task automatic push_exp(input int p, input logic [3:0] tag, input logic res);
      exp_q.push_back({1'(p), tag, 64'(res)});
   endtask

   task automatic do_reset();
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      exp_q.delete();
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         req_valid = 2'b00;
         rsp_ready = 2'b11;
         #1;
         monitor();
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [1:0] g;
      int         cnt[2];
      logic [3:0] t;

      vecs[0]  = '{1'b0, 3'b000, 64'd5, 64'd5, 4'd3,  1'b1};
      vecs[1]  = '{1'b1, 3'b100, ALL1,  64'd1, 4'd4,  1'b1};
      vecs[2]  = '{1'b1, 3'b110, ALL1,  64'd1, 4'd5,  1'b0};
      vecs[3]  = '{1'b1, 3'b111, ALL1,  64'd1, 4'd6,  1'b1};
      vecs[4]  = '{1'b1, 3'b011, ALL1,  64'd1, 4'd7,  1'b0};
      vecs[5]  = '{1'b1, 3'b101, ALL1,  64'd1, 4'd8,  1'b0};
      vecs[6]  = '{1'b0, 3'b001, 64'd5, 64'd5, 4'd9,  1'b0};
      vecs[7]  = '{1'b0, 3'b001, 64'd5, 64'd6, 4'd10, 1'b1};
      vecs[8]  = '{1'b0, 3'b000, 64'd5, 64'd6, 4'd11, 1'b0};
      vecs[9]  = '{1'b0, 3'b010, 64'd5, 64'd5, 4'd12, 1'b0};
      vecs[10] = '{1'b1, 3'b100, MINS,  MAXS,  4'd13, 1'b1};
      vecs[11] = '{1'b1, 3'b110, MINS,  MAXS,  4'd14, 1'b0};
      vecs[12] = '{1'b0, 3'b111, 64'd1, ALL1,  4'd15, 1'b0};
      vecs[13] = '{1'b0, 3'b101, 64'd5, 64'd5, 4'd0,  1'b1};

      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      #1;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_result", rsp_result, 64'd0);
      chk("reset_rsp_tag", 64'(rsp_tag), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      do_reset();

      // table-driven single operations with exact latency
      for (int i = 0; i < 14; i++) begin
         cycle_begin();
         req_valid = vecs[i].port ? 2'b10 : 2'b01;
         set_req(int'(vecs[i].port), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
         rsp_ready = 2'b11;
         cycle_end(g);
         chk("vec_grant", 64'(g), vecs[i].port ? 64'd2 : 64'd1);
         if (g != 2'b00) push_exp(int'(vecs[i].port), vecs[i].tag, vecs[i].exp);
         cycle_begin();
         req_valid = 2'b00;
         cycle_end(g);
         chk("vec_lat_s1", 64'(rsp_valid), 64'd0);
         cycle_begin();
         cycle_end(g);
         chk("vec_lat_s2", 64'(exp_q.size()), 64'd0);
      end
      drain();

      // round robin with both ports requesting continuously
      do_reset();
      cnt[0] = 0;
      cnt[1] = 0;
      for (int c = 0; c < 4; c++) begin
         cycle_begin();
         req_valid = 2'b11;
         for (int p = 0; p < 2; p++)
            set_req(p, 3'b000, 64'(c), 64'(c), 4'(2 * cnt[p] + p));
         cycle_end(g);
         chk("rr_grant", 64'(g), (c % 2 == 0) ? 64'd1 : 64'd2);
         for (int p = 0; p < 2; p++)
            if (g[p]) begin
               push_exp(p, req_tag[p], 1'b1);
               cnt[p]++;
            end
      end
      drain();

      // backpressure: fill both stages, hold, release
      do_reset();
      cycle_begin();
      rsp_ready = 2'b00;
      req_valid = 2'b01;
      set_req(0, 3'b000, 64'd7, 64'd7, 4'd1);
      cycle_end(g);
      chk("bp_first", 64'(g), 64'd1);
      if (g[0]) push_exp(0, 4'd1, 1'b1);
      cycle_begin();
      req_valid = 2'b10;
      set_req(1, 3'b110, 64'd1, 64'd2, 4'd2);
      cycle_end(g);
      chk("bp_second", 64'(g), 64'd2);
      if (g[1]) push_exp(1, 4'd2, 1'b1);
      cycle_begin();
      req_valid = 2'b11;
      set_req(0, 3'b000, 64'd0, 64'd0, 4'd3);
      cycle_end(g);
      chk("bp_full", 64'(req_ready), 64'd0);
      for (int k = 0; k < 5; k++) begin
         cycle_begin();
         cycle_end(g);
         chk("bp_hold_ready", 64'(req_ready), 64'd0);
         chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
         chk("bp_hold_tag", 64'(rsp_tag), 64'd1);
         chk("bp_hold_result", rsp_result, 64'd1);
      end
      cycle_begin();
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      cycle_end(g);
      cycle_begin();
      cycle_end(g);
      chk("bp_in_order", 64'(exp_q.size()), 64'd0);
      cycle_begin();
      req_valid = 2'b01;
      set_req(0, 3'b001, 64'd4, 64'd9, 4'd5);
      cycle_end(g);
      chk("bp_reassert", 64'(g), 64'd1);
      if (g[0]) push_exp(0, 4'd5, 1'b1);
      drain();

      // streaming: port 1 alone, back-to-back
      do_reset();
      for (int c = 0; c < 10; c++) begin
         cycle_begin();
         rsp_ready = 2'b11;
         req_valid = (c < 8) ? 2'b10 : 2'b00;
         t = 4'(c + 2);
         set_req(1, (c % 2 == 0) ? 3'b100 : 3'b110, 64'(c) - 64'd4, 64'd1, t);
         cycle_end(g);
         if (c < 8) begin
            chk("stream_grant", 64'(g), 64'd2);
            if (g[1]) push_exp(1, t, ref_cmp(req_op[1], req_a[1], req_b[1]));
         end
         if (c >= 2) chk("stream_no_bubble", 64'(rsp_valid), 64'd2);
      end
      drain();

      // reset with both stages occupied
      do_reset();
      cycle_begin();
      rsp_ready = 2'b00;
      req_valid = 2'b01;
      set_req(0, 3'b000, 64'd1, 64'd1, 4'd1);
      cycle_end(g);
      if (g[0]) push_exp(0, 4'd1, 1'b1);
      cycle_begin();
      set_req(0, 3'b000, 64'd1, 64'd2, 4'd2);
      cycle_end(g);
      if (g[0]) push_exp(0, 4'd2, 1'b0);
      cycle_begin();
      req_valid = 2'b00;
      cycle_end(g);
      chk("rst_pre_full", 64'(rsp_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cycle_begin();
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      set_req(0, 3'b000, 64'd3, 64'd3, 4'd6);
      set_req(1, 3'b001, 64'd3, 64'd3, 4'd7);
      cycle_end(g);
      chk("rst_first_conflict", 64'(g), 64'd1);
      if (g[0]) push_exp(0, 4'd6, 1'b1);
      cycle_begin();
      set_req(0, 3'b000, 64'd3, 64'd4, 4'd8);
      cycle_end(g);
      chk("rst_second_conflict", 64'(g), 64'd2);
      if (g[1]) push_exp(1, 4'd7, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
